ram_arbiter: RTL and testbench

Single-port arbiter and access sequencer between the CPU's instruction-fetch and data (load/store) paths and the shared word-organised RAM. Each cycle it grants at most one requester, drives the RAM control/address/write-data bus, and registers the read result. It performs alignment checking and load sign-extension, and returns one-cycle-latency responses. Data accesses have priority, with a bounded-starvation guarantee for fetch.

---
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter.sv | 64 ++++++
 tb/tb_ram_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: fetch, data and RAM bus signals shared by the CPU side, the arbiter and the RAM.
interface ram_arbiter_if;
    logic        i_valid;
    logic [31:0] i_address;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_error;
    logic        d_valid;
    logic [3:0]  d_control;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_error;
    logic [3:0]  ram_control;
    logic [31:0] ram_address;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    modport master (
        output i_valid, i_address, d_valid, d_control, d_address, d_wdata, ram_read_data,
        input  i_ready, i_rvalid, i_rdata, i_error, d_ready, d_rvalid, d_rdata, d_error,
        input  ram_control, ram_address, ram_write_data
    );
    modport slave (
        input  i_valid, i_address, d_valid, d_control, d_address, d_wdata, ram_read_data,
        output i_ready, i_rvalid, i_rdata, i_error, d_ready, d_rvalid, d_rdata, d_error,
        output ram_control, ram_address, ram_write_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port RAM arbiter, data-priority with bounded fetch starvation, one-cycle responses.
module ram_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input logic         clock,
    input logic         reset,
    ram_arbiter_if.slave bus
);
    logic [3:0]  r_streak;
    logic        r_i_rvalid, r_i_error, r_d_rvalid, r_d_error;
    logic [31:0] r_i_rdata, r_d_rdata;
    logic        w_at_max, w_gnt_d, w_gnt_i, w_derr, w_i_mis;
    logic [3:0]  w_c;
    logic [31:0] w_rd, w_ext;

    assign w_c      = bus.d_control;
    assign w_rd     = bus.ram_read_data;
    assign w_at_max = r_streak == 4'(MAX_DATA_STREAK);
    assign w_gnt_d  = bus.d_valid & ~(bus.i_valid & w_at_max);
    assign w_gnt_i  = bus.i_valid & ~w_gnt_d;
    assign w_i_mis  = |bus.i_address[1:0];
    assign w_derr   = (w_c[1] & w_c[2])
                    | (~w_c[1] & ~w_c[2] & |bus.d_address[1:0])
                    | (w_c[2] & bus.d_address[0]);
    assign w_ext    = w_c[3] ? w_rd
                    : w_c[1] ? {{24{w_rd[7]}}, w_rd[7:0]}
                    : w_c[2] ? {{16{w_rd[15]}}, w_rd[15:0]}
                    : w_rd;

    assign bus.i_ready        = w_gnt_i;
    assign bus.d_ready        = w_gnt_d;
    // Erroneous accesses still occupy the bus but never write.
    assign bus.ram_control    = w_gnt_d ? {w_c[3:1], w_c[0] & ~w_derr} : 4'b0000;
    assign bus.ram_address    = w_gnt_d ? bus.d_address : w_gnt_i ? bus.i_address : 32'b0;
    assign bus.ram_write_data = w_gnt_d ? bus.d_wdata : 32'b0;

    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.i_error  = r_i_error;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_error  = r_d_error;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_streak   <= 4'd0;
            r_i_rvalid <= 1'b0;
            r_i_error  <= 1'b0;
            r_i_rdata  <= 32'b0;
            r_d_rvalid <= 1'b0;
            r_d_error  <= 1'b0;
            r_d_rdata  <= 32'b0;
        end else begin
            r_streak   <= (!bus.i_valid || w_gnt_i) ? 4'd0
                        : (w_gnt_d && !w_at_max) ? r_streak + 4'd1 : r_streak;
            r_i_rvalid <= w_gnt_i;
            r_i_error  <= w_gnt_i & w_i_mis;
            r_i_rdata  <= (w_gnt_i && !w_i_mis) ? w_rd : 32'b0;
            r_d_rvalid <= w_gnt_d;
            r_d_error  <= w_gnt_d & w_derr;
            r_d_rdata  <= (w_gnt_d && !w_c[0] && !w_derr) ? w_ext : 32'b0;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against ram_arbiter with a word RAM model behind it.
module tb_ram_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] mem [0:63];
    logic [31:0] w_word;

    always #5 clock = ~clock;

    ram_arbiter_if bus ();
    ram_arbiter #(.MAX_DATA_STREAK(4)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    // RAM returns byte/halfword lanes already shifted down and zero-extended.
    always_comb begin
        w_word = mem[bus.ram_address[7:2]];
        bus.ram_read_data = bus.ram_control[1] ? ((w_word >> {bus.ram_address[1:0], 3'b000}) & 32'hFF)
                          : bus.ram_control[2] ? ((w_word >> {bus.ram_address[1], 4'b0000}) & 32'hFFFF)
                          : w_word;
    end

    always @(posedge clock) begin
        if (bus.ram_control[0]) begin
            if (bus.ram_control[1])
                mem[bus.ram_address[7:2]][{bus.ram_address[1:0], 3'b000} +: 8] <= bus.ram_write_data[7:0];
            else if (bus.ram_control[2])
                mem[bus.ram_address[7:2]][{bus.ram_address[1], 4'b0000} +: 16] <= bus.ram_write_data[15:0];
            else
                mem[bus.ram_address[7:2]] <= bus.ram_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.i_valid   = 1'b0;
        bus.i_address = 32'h0;
        bus.d_valid   = 1'b0;
        bus.d_control = 4'h0;
        bus.d_address = 32'h0;
        bus.d_wdata   = 32'h0;
    endtask

    task automatic dacc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w);
        bus.d_valid   = 1'b1;
        bus.d_control = c;
        bus.d_address = a;
        bus.d_wdata   = w;
        #1;
        chk("d_ready", {31'b0, bus.d_ready}, 32'd1);
        step();
        bus.d_valid = 1'b0;
    endtask

    task automatic dresp(input string tag, input logic [31:0] rdata, input logic err);
        chk({tag, ".rvalid"}, {31'b0, bus.d_rvalid}, 32'd1);
        chk({tag, ".rdata"}, bus.d_rdata, rdata);
        chk({tag, ".error"}, {31'b0, bus.d_error}, {31'b0, err});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        idle();
        step();
        step();
        chk("rst.i_rvalid", {31'b0, bus.i_rvalid}, 32'd0);
        chk("rst.d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        chk("rst.i_rdata", bus.i_rdata, 32'd0);
        chk("rst.d_rdata", bus.d_rdata, 32'd0);
        chk("rst.errors", {30'b0, bus.i_error, bus.d_error}, 32'd0);
        reset = 1'b1;
        step();
        chk("idle.ram_control", {28'b0, bus.ram_control}, 32'd0);
        chk("idle.ram_address", bus.ram_address, 32'd0);
        chk("idle.readys", {30'b0, bus.i_ready, bus.d_ready}, 32'd0);

        bus.i_valid = 1'b1;
        bus.i_address = 32'h10;
        #1;
        chk("fetch.readys", {30'b0, bus.i_ready, bus.d_ready}, 32'd2);
        chk("fetch.ram_address", bus.ram_address, 32'h10);
        chk("fetch.ram_control", {28'b0, bus.ram_control}, 32'd0);
        step();
        bus.i_valid = 1'b0;
        chk("fetch.rvalid", {31'b0, bus.i_rvalid}, 32'd1);
        chk("fetch.rdata", bus.i_rdata, 32'hDEADBEEF);
        chk("fetch.error", {31'b0, bus.i_error}, 32'd0);
        step();
        chk("fetch.pulse", {31'b0, bus.i_rvalid}, 32'd0);

        bus.i_valid = 1'b1;
        bus.i_address = 32'h11;
        #1;
        chk("misfetch.ram_address", bus.ram_address, 32'h11);
        step();
        bus.i_valid = 1'b0;
        chk("misfetch.error", {31'b0, bus.i_error}, 32'd1);
        chk("misfetch.rdata", bus.i_rdata, 32'd0);

        mem[4] = 32'h80FF7F01;
        dacc(4'b0010, 32'h13, 32'h0);
        dresp("lb", 32'hFFFFFF80, 1'b0);
        dacc(4'b1010, 32'h13, 32'h0);
        dresp("lbu", 32'h00000080, 1'b0);
        dacc(4'b0100, 32'h12, 32'h0);
        dresp("lh", 32'hFFFF80FF, 1'b0);
        dacc(4'b1100, 32'h12, 32'h0);
        dresp("lhu", 32'h000080FF, 1'b0);
        dacc(4'b0010, 32'h10, 32'h0);
        dresp("lb.pos", 32'h00000001, 1'b0);

        dacc(4'b0011, 32'h21, 32'h000000AA);
        dresp("sb", 32'h0, 1'b0);
        dacc(4'b0000, 32'h20, 32'h0);
        dresp("lw.after_sb", 32'h1122AA44, 1'b0);
        step();
        chk("d.pulse", {31'b0, bus.d_rvalid}, 32'd0);

        bus.d_valid = 1'b1;
        bus.d_control = 4'b0001;
        bus.d_address = 32'h22;
        bus.d_wdata = 32'hFFFFFFFF;
        #1;
        chk("sw_mis.ram_control", {28'b0, bus.ram_control}, 32'd0);
        step();
        bus.d_valid = 1'b0;
        dresp("sw_mis", 32'h0, 1'b1);
        chk("sw_mis.mem", mem[8], 32'h1122AA44);
        dacc(4'b0100, 32'h21, 32'h0);
        dresp("lh_odd", 32'h0, 1'b1);
        dacc(4'b0110, 32'h20, 32'h0);
        dresp("bh_both", 32'h0, 1'b1);
        step();

        bus.i_valid = 1'b1;
        bus.i_address = 32'h10;
        bus.d_valid = 1'b1;
        bus.d_control = 4'b0000;
        bus.d_address = 32'h20;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk($sformatf("streak[%0d]", k), {30'b0, bus.i_ready, bus.d_ready}, (k % 5 == 4) ? 32'd2 : 32'd1);
            step();
        end

        idle();
        step();
        bus.i_valid = 1'b1;
        bus.d_valid = 1'b1;
        bus.i_address = 32'h10;
        bus.d_address = 32'h20;
        step();
        step();
        chk("pre_rst.d_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
        reset = 1'b0;
        idle();
        #1;
        chk("rst_async.d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst.rvalids", {30'b0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        bus.i_valid = 1'b1;
        bus.d_valid = 1'b1;
        bus.i_address = 32'h10;
        bus.d_address = 32'h20;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("restreak[%0d]", k), {30'b0, bus.i_ready, bus.d_ready}, (k == 4) ? 32'd2 : 32'd1);
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
